mem_port_sequencer: RTL and testbench

//  Sequences every access to the 16-bit tag memory array: precharge, then wordline plus write or sense, then recover.

---
 rtl/mem_port_sequencer_if.sv | 51 +++++
 rtl/mem_port_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_mem_port_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_sequencer_if.sv
// Port bundle for mem_port_sequencer: cmd/log requester handshakes plus the tag-array pins.
// master = requesters and array environment, slave = the sequencer itself.
`timescale 1ns/1ps
interface mem_port_sequencer_if;
  logic        cmd_req;
  logic        cmd_we;
  logic [5:0]  cmd_addr;
  logic [2:0]  cmd_sel;
  logic [15:0] cmd_wdata;
  logic        cmd_gnt;
  logic        cmd_done;
  logic        cmd_err;
  logic [15:0] cmd_rdata;

  logic        log_req;
  logic        log_we;
  logic [5:0]  log_addr;
  logic [2:0]  log_sel;
  logic [15:0] log_wdata;
  logic        log_gnt;
  logic        log_done;
  logic        log_err;
  logic [15:0] log_rdata;

  logic [15:0] mem_read_in;
  logic        PC_B;
  logic        WE;
  logic        SE;
  logic [5:0]  mem_address;
  logic [2:0]  mem_sel;
  logic [15:0] mem_data_out;
  logic        busy;

  modport master (
    output cmd_req, cmd_we, cmd_addr, cmd_sel, cmd_wdata,
    input  cmd_gnt, cmd_done, cmd_err, cmd_rdata,
    output log_req, log_we, log_addr, log_sel, log_wdata,
    input  log_gnt, log_done, log_err, log_rdata,
    output mem_read_in,
    input  PC_B, WE, SE, mem_address, mem_sel, mem_data_out, busy
  );

  modport slave (
    input  cmd_req, cmd_we, cmd_addr, cmd_sel, cmd_wdata,
    output cmd_gnt, cmd_done, cmd_err, cmd_rdata,
    input  log_req, log_we, log_addr, log_sel, log_wdata,
    output log_gnt, log_done, log_err, log_rdata,
    input  mem_read_in,
    output PC_B, WE, SE, mem_address, mem_sel, mem_data_out, busy
  );
endinterface

// File: rtl/mem_port_sequencer.sv
// Tag-array port sequencer: arbitrates cmd/log requesters and runs precharge/access/recover.
// Optional write readback verify is enabled by defining MEM_PORT_WRITE_VERIFY_EN.
`timescale 1ns/1ps
module mem_port_sequencer #(
  parameter int unsigned T_PRE      = 2,
  parameter int unsigned T_WR       = 2,
  parameter int unsigned T_SENSE    = 2,
  parameter int unsigned DEPTH      = 48,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_sequencer_if.slave  bus
);

  localparam int unsigned     SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [7:0]      PRE_LAST   = 8'(T_PRE - 1);
  localparam logic [7:0]      WR_LAST    = 8'(T_WR - 1);
  localparam logic [7:0]      SENSE_LAST = 8'(T_SENSE - 1);
  localparam logic [6:0]      DEPTH_LIM  = 7'(DEPTH);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ACC,
    VPRE,
    VACC,
    REC
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [5:0]    addr_q, addr_d;
  logic [2:0]    sel_q, sel_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [15:0]   cmdRdata_q, cmdRdata_d;
  logic [15:0]   logRdata_q, logRdata_d;
  logic [SW-1:0] starveCnt_q, starveCnt_d;

  logic          grantCmd, grantLog;
  logic          reqWe;
  logic [5:0]    reqAddr;
  logic [2:0]    reqSel;
  logic [15:0]   reqWdata;
  logic          captureRd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      sel_q       <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      cmdRdata_q  <= '0;
      logRdata_q  <= '0;
      starveCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      cmdRdata_q  <= cmdRdata_d;
      logRdata_q  <= logRdata_d;
      starveCnt_q <= starveCnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    cmdRdata_d  = cmdRdata_q;
    logRdata_d  = logRdata_q;
    starveCnt_d = starveCnt_q;
    grantCmd    = 1'b0;
    grantLog    = 1'b0;
    captureRd   = 1'b0;
    reqWe       = 1'b0;
    reqAddr     = '0;
    reqSel      = '0;
    reqWdata    = '0;

    if (!bus.log_req) starveCnt_d = '0;

    case (state_q)
      IDLE: begin
        // cmd normally wins; log is forced through once cmd has had STARVE_MAX grants in a row
        if (bus.cmd_req && !(bus.log_req && starveCnt_q == STARVE_LIM)) grantCmd = 1'b1;
        else if (bus.log_req)                                          grantLog = 1'b1;

        reqWe    = grantLog ? bus.log_we    : bus.cmd_we;
        reqAddr  = grantLog ? bus.log_addr  : bus.cmd_addr;
        reqSel   = grantLog ? bus.log_sel   : bus.cmd_sel;
        reqWdata = grantLog ? bus.log_wdata : bus.cmd_wdata;

        if (grantCmd || grantLog) begin
          owner_d = grantLog;
          we_d    = reqWe;
          cnt_d   = '0;
          if ({1'b0, reqAddr} < DEPTH_LIM) begin
            addr_d  = reqAddr;
            sel_d   = reqSel;
            if (reqWe) wdata_d = reqWdata;
            err_d   = 1'b0;
            state_d = PRE;
          end else begin
            err_d   = 1'b1;
            state_d = REC;
          end
        end

        if (grantCmd && bus.log_req && starveCnt_q != STARVE_LIM)
          starveCnt_d = starveCnt_q + 1'b1;
        if (grantLog) starveCnt_d = '0;
      end

      PRE: begin
        if (cnt_q == PRE_LAST) begin
          cnt_d   = '0;
          state_d = ACC;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ACC: begin
        if ((we_q && cnt_q == WR_LAST) || (!we_q && cnt_q == SENSE_LAST)) begin
          cnt_d     = '0;
          captureRd = !we_q;
          if (we_q) begin
`ifdef MEM_PORT_WRITE_VERIFY_EN
            state_d = VPRE;
`else
            state_d = REC;
`endif
          end else begin
            state_d = REC;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      VPRE: begin
        if (cnt_q == PRE_LAST) begin
          cnt_d   = '0;
          state_d = VACC;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      VACC: begin
        if (cnt_q == SENSE_LAST) begin
          cnt_d     = '0;
          captureRd = 1'b1;
          err_d     = (bus.mem_read_in != wdata_q);
          state_d   = REC;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      REC: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    if (captureRd) begin
      if (owner_q) logRdata_d = bus.mem_read_in;
      else         cmdRdata_d = bus.mem_read_in;
    end
  end

  // Array pins decode straight from state so a reset drops them in the same cycle
  assign bus.PC_B         = !(state_q == PRE || state_q == VPRE);
  assign bus.WE           = (state_q == ACC) && we_q;
  assign bus.SE           = ((state_q == ACC) && !we_q) || (state_q == VACC);
  assign bus.mem_address  = addr_q;
  assign bus.mem_sel      = sel_q;
  assign bus.mem_data_out = wdata_q;
  assign bus.busy         = (state_q != IDLE);

  assign bus.cmd_gnt   = (state_q != IDLE) && !owner_q;
  assign bus.log_gnt   = (state_q != IDLE) && owner_q;
  assign bus.cmd_done  = (state_q == REC) && !owner_q;
  assign bus.log_done  = (state_q == REC) && owner_q;
  assign bus.cmd_err   = bus.cmd_done && err_q;
  assign bus.log_err   = bus.log_done && err_q;
  assign bus.cmd_rdata = cmdRdata_q;
  assign bus.log_rdata = logRdata_q;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Self-checking bench for mem_port_sequencer with a behavioural array and transaction-level model.
// Build with MEM_PORT_WRITE_VERIFY_EN defined to exercise the write readback variant.
`timescale 1ns/1ps
module tb_mem_port_sequencer;

  localparam int T_PRE      = 2;
  localparam int T_WR       = 2;
  localparam int T_SENSE    = 2;
  localparam int DEPTH      = 48;
  localparam int STARVE_MAX = 4;
`ifdef MEM_PORT_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  bit   forceZero;

  mem_port_sequencer_if bus();

  mem_port_sequencer #(
    .T_PRE(T_PRE), .T_WR(T_WR), .T_SENSE(T_SENSE), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Physical array: written while WE is high, sensed combinationally at the current wordline
  logic [15:0] arr [64];
  always @(posedge clk) if (bus.WE) arr[bus.mem_address] <= bus.mem_data_out;
  assign bus.mem_read_in = forceZero ? 16'h0000 : arr[bus.mem_address];

  logic [15:0] modelMem [64];
  logic [15:0] expRdata [2];
  logic [5:0]  writtenAddrs [$];
  int nCompared   = 0;
  int nMismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic driveFields(input bit isLog, input bit req, input bit we, input logic [5:0] addr,
                             input logic [2:0] sel, input logic [15:0] wdata);
    if (isLog) begin
      bus.log_req = req; bus.log_we = we; bus.log_addr = addr; bus.log_sel = sel; bus.log_wdata = wdata;
    end else begin
      bus.cmd_req = req; bus.cmd_we = we; bus.cmd_addr = addr; bus.cmd_sel = sel; bus.cmd_wdata = wdata;
    end
  endtask

  task automatic dropReq(input bit isLog);
    if (isLog) bus.log_req = 1'b0;
    else       bus.cmd_req = 1'b0;
  endtask

  // One access from one requester, observed cycle by cycle until its done pulse
  task automatic applyStimulus(input bit isLog, input bit we, input logic [5:0] addr, input logic [2:0] sel,
                               input logic [15:0] wdata, input bit mutate, input string tag);
    int lat = 0, preCnt = 0, weCnt = 0, seCnt = 0, badAddr = 0, badData = 0, otherDone = 0;
    int expLat, expPre, expWe, expSe;
    logic expErr;
    logic gntSeen = 1'b0;
    logic obsErr = 1'b0;
    logic [15:0] obsRdata = '0;
    logic [15:0] readback = forceZero ? 16'h0000 : wdata;
    bit inRange = (int'(addr) < DEPTH);

    if (!inRange) begin
      expLat = 2; expPre = 0; expWe = 0; expSe = 0; expErr = 1'b1;
    end else if (!we) begin
      expLat = 1 + T_PRE + T_SENSE + 1; expPre = T_PRE; expWe = 0; expSe = T_SENSE; expErr = 1'b0;
      expRdata[isLog] = forceZero ? 16'h0000 : modelMem[addr];
    end else if (VERIFY) begin
      expLat = 1 + 2 * T_PRE + T_WR + T_SENSE + 1; expPre = 2 * T_PRE; expWe = T_WR; expSe = T_SENSE;
      expErr = (readback != wdata);
      expRdata[isLog] = readback;
    end else begin
      expLat = 1 + T_PRE + T_WR + 1; expPre = T_PRE; expWe = T_WR; expSe = 0; expErr = 1'b0;
    end
    if (inRange && we) begin
      modelMem[addr] = wdata;
      writtenAddrs.push_back(addr);
    end

    @(negedge clk);
    driveFields(isLog, 1'b1, we, addr, sel, wdata);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!bus.PC_B) preCnt++;
      if (bus.WE)    weCnt++;
      if (bus.SE)    seCnt++;
      if ((!bus.PC_B || bus.WE || bus.SE) && (bus.mem_address !== addr || bus.mem_sel !== sel)) badAddr++;
      if (bus.WE && bus.mem_data_out !== wdata) badData++;
      if (k == 1) gntSeen = isLog ? bus.log_gnt : bus.cmd_gnt;
      if (isLog ? bus.cmd_done : bus.log_done) otherDone++;
      if (isLog ? bus.log_done : bus.cmd_done) begin
        lat      = k + 1;
        obsErr   = isLog ? bus.log_err : bus.cmd_err;
        obsRdata = isLog ? bus.log_rdata : bus.cmd_rdata;
        dropReq(isLog);
        break;
      end
      if (mutate && k == 2) driveFields(isLog, 1'b1, we, addr ^ 6'h15, sel ^ 3'h5, ~wdata);
    end
    if (lat == 0) dropReq(isLog);

    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_pcbLowCycles"}, 32'(preCnt), 32'(expPre));
    checkOutput({tag, "_weCycles"}, 32'(weCnt), 32'(expWe));
    checkOutput({tag, "_seCycles"}, 32'(seCnt), 32'(expSe));
    checkOutput({tag, "_err"}, 32'(obsErr), 32'(expErr));
    checkOutput({tag, "_rdata"}, 32'(obsRdata), 32'(expRdata[isLog]));
    checkOutput({tag, "_addrSelStable"}, 32'(badAddr), 32'd0);
    checkOutput({tag, "_dataStable"}, 32'(badData), 32'd0);
    checkOutput({tag, "_gnt"}, 32'(gntSeen), 32'd1);
    checkOutput({tag, "_otherDone"}, 32'(otherDone), 32'd0);

    @(negedge clk);
    checkOutput({tag, "_donePulseOnce"}, 32'(isLog ? bus.log_done : bus.cmd_done), 32'd0);
    checkOutput({tag, "_idleAfter"}, 32'(bus.busy), 32'd0);
  endtask

  // Both requesters held high: log must break through after every STARVE_MAX cmd grants
  task automatic checkArbitration();
    int order [$];
    logic [5:0] ca = writtenAddrs[0];
    logic [5:0] la = writtenAddrs[writtenAddrs.size() - 1];
    @(negedge clk);
    driveFields(1'b0, 1'b1, 1'b0, ca, 3'd2, 16'h0000);
    driveFields(1'b1, 1'b1, 1'b0, la, 3'd6, 16'h0000);
    for (int k = 0; k < 300 && order.size() < 10; k++) begin
      @(negedge clk);
      if (bus.cmd_done) order.push_back(0);
      if (bus.log_done) order.push_back(1);
    end
    dropReq(1'b0);
    dropReq(1'b1);
    checkOutput("arb_count", 32'(order.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      checkOutput($sformatf("arb_grant%0d", i), (i < order.size()) ? 32'(order[i]) : 32'hFFFF,
                  32'((i % (STARVE_MAX + 1)) == STARVE_MAX));
    expRdata[0] = modelMem[ca];
    expRdata[1] = modelMem[la];
    @(negedge clk);
  endtask

  initial begin
    logic       rIsLog, rWe;
    logic [5:0] rAddr;
    int         seWait;

    reset = 1'b0;
    forceZero = 1'b0;
    driveFields(1'b0, 1'b0, 1'b0, 6'd0, 3'd0, 16'h0000);
    driveFields(1'b1, 1'b0, 1'b0, 6'd0, 3'd0, 16'h0000);
    expRdata[0] = 16'h0000;
    expRdata[1] = 16'h0000;
    repeat (3) @(negedge clk);
    checkOutput("rst_PC_B", 32'(bus.PC_B), 32'd1);
    checkOutput("rst_WE", 32'(bus.WE), 32'd0);
    checkOutput("rst_SE", 32'(bus.SE), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_gnt", 32'({bus.cmd_gnt, bus.log_gnt}), 32'd0);
    checkOutput("rst_done", 32'({bus.cmd_done, bus.log_done}), 32'd0);
    checkOutput("rst_memAddr", 32'(bus.mem_address), 32'd0);
    checkOutput("rst_rdata", 32'(bus.cmd_rdata), 32'd0);
    reset = 1'b1;
    $display("[TB] reset released");

    applyStimulus(1'b0, 1'b1, 6'd5, 3'd1, 16'hA5C3, 1'b0, "seedWrite");
    applyStimulus(1'b0, 1'b0, 6'd5, 3'd1, 16'h0000, 1'b0, "t1_cmdRead");
    applyStimulus(1'b1, 1'b1, 6'd47, 3'd3, 16'h1234, 1'b0, "t2_logWrite");
    forceZero = 1'b1;
    applyStimulus(1'b1, 1'b1, 6'd47, 3'd3, 16'h1234, 1'b0, "t2_logWriteForced");
    forceZero = 1'b0;
    applyStimulus(1'b0, 1'b0, 6'd48, 3'd2, 16'h0000, 1'b0, "t3_cmdOutOfRange");
    applyStimulus(1'b1, 1'b1, 6'd63, 3'd4, 16'hBEEF, 1'b0, "t3_logOutOfRange");

    for (int i = 0; i < 12; i++) begin
      rIsLog = 1'($urandom_range(0, 1));
      rWe    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) rAddr = 6'(48 + $urandom_range(0, 15));
      else if (!rWe)                 rAddr = writtenAddrs[$urandom_range(0, writtenAddrs.size() - 1)];
      else                           rAddr = 6'($urandom_range(0, 47));
      applyStimulus(rIsLog, rWe, rAddr, 3'($urandom), 16'($urandom), 1'b0, $sformatf("rnd%0d", i));
    end

    applyStimulus(1'b0, 1'b1, 6'($urandom_range(0, 47)), 3'd5, 16'($urandom), 1'b1, "t6_mutateWrite");
    applyStimulus(1'b0, 1'b0, writtenAddrs[writtenAddrs.size() - 1], 3'd5, 16'h0000, 1'b0, "t6_readBack");

    checkArbitration();

    @(negedge clk);
    driveFields(1'b0, 1'b1, 1'b0, 6'd5, 3'd1, 16'h0000);
    seWait = 0;
    while (!bus.SE && seWait < 20) begin
      @(negedge clk);
      seWait++;
    end
    checkOutput("t5_reachedSense", 32'(bus.SE), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("t5_SE", 32'(bus.SE), 32'd0);
    checkOutput("t5_PC_B", 32'(bus.PC_B), 32'd1);
    checkOutput("t5_WE", 32'(bus.WE), 32'd0);
    checkOutput("t5_busy", 32'(bus.busy), 32'd0);
    checkOutput("t5_done", 32'(bus.cmd_done), 32'd0);
    bus.cmd_req = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t5_noDoneInReset", 32'(bus.cmd_done), 32'd0);
    reset = 1'b1;
    expRdata[0] = 16'h0000;
    expRdata[1] = 16'h0000;
    applyStimulus(1'b1, 1'b0, writtenAddrs[0], 3'd7, 16'h0000, 1'b0, "t5_logReadAfterReset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
